// File: rtl/ph_reg3_xfer_ctrl_pkg.sv
// Shared types and constants for the ph_reg3 FIFO-to-stream transfer controller.
// The watchdog constants are only consumed when PH_REG3_XFER_TIMEOUT_EN is defined.
package ph_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        READ  = 3'd2,
        HOLD  = 3'd3,
        GUARD = 3'd4
    } xfer_state_t;

    localparam int         GUARD_CYC_DEF = 2;
    localparam int         WDOG_W        = 8;
    localparam logic [7:0] WDOG_LIMIT    = 8'd255;

    // Width of a down-counter that must hold GUARD_CYC-1.
    function automatic int guard_cnt_w(input int cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/ph_reg3_xfer_ctrl_wdog.sv
// ph_xfer_wdog: counts consecutive enabled cycles and flags when the limit is reached.
// Instantiated by ph_reg3_xfer_ctrl only when PH_REG3_XFER_TIMEOUT_EN is defined.
module ph_xfer_wdog
    import ph_xfer_pkg::*;
(
    input  logic h_phi2,
    input  logic h_rst_b,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WDOG_W-1:0] wait_cnt;

    always_ff @(posedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (enable && (wait_cnt != WDOG_LIMIT)) begin
            wait_cnt <= wait_cnt + WDOG_W'(1);
        end
    end

    // Fires in the cycle whose increment brings the consecutive count to the limit.
    assign expired = enable && !clear && (wait_cnt == (WDOG_LIMIT - 8'd1));

endmodule

// File: rtl/ph_reg3_xfer_ctrl.sv
// ph_reg3_xfer_ctrl: moves bytes from the host FIFO onto a ready/valid byte stream.
// Optional WAIT watchdog with sticky err: define PH_REG3_XFER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transfer in progress; accepts start
// WAIT  | waiting for FIFO data (or the odd tail byte in two-byte mode)
// READ  | single-cycle FIFO strobe, byte captured into out_data
// HOLD  | byte offered on the stream until out_ready
// GUARD | settle time for the FIFO flag synchronisers
module ph_reg3_xfer_ctrl
    import ph_xfer_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int GUARD_CYC = GUARD_CYC_DEF
) (
    input  logic             h_phi2,
    input  logic             h_rst_b,

    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             one_byte_mode,
    input  logic             abort,

    input  logic             h_data_available,
    input  logic             h_zero_bytes_available,
    input  logic [7:0]       h_data,
    output logic             fifo_sel,
    output logic             fifo_rd,

    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,

    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] remaining
);

    localparam int               GRD_W    = guard_cnt_w(GUARD_CYC);
    localparam logic [GRD_W-1:0] GRD_LOAD = (GUARD_CYC > 0) ? GRD_W'(GUARD_CYC - 1) : '0;

    xfer_state_t      state, state_n;
    logic [CNT_W-1:0] rem_n;
    logic             mode, mode_n;
    logic             pair, pair_n;
    logic [7:0]       data_n;
    logic             done_n;
    logic [GRD_W-1:0] grd_cnt, grd_n;
    logic             wdog_expired;
    logic             tail_ready;

    always_ff @(posedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            state     <= IDLE;
            remaining <= '0;
            mode      <= 1'b1;
            pair      <= 1'b0;
            out_data  <= 8'h00;
            done      <= 1'b0;
            grd_cnt   <= '0;
        end else begin
            state     <= state_n;
            remaining <= rem_n;
            mode      <= mode_n;
            pair      <= pair_n;
            out_data  <= data_n;
            done      <= done_n;
            grd_cnt   <= grd_n;
        end
    end

    // Two-byte mode with a single byte left: the zero-bytes flag is the only hint it has landed.
    assign tail_ready = !mode && (remaining == CNT_W'(1)) && !h_zero_bytes_available;

    always_comb begin
        state_n = state;
        rem_n   = remaining;
        mode_n  = mode;
        pair_n  = pair;
        data_n  = out_data;
        done_n  = 1'b0;
        grd_n   = grd_cnt;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (len == '0) begin
                        done_n = 1'b1;
                    end else begin
                        rem_n   = len;
                        mode_n  = one_byte_mode;
                        pair_n  = 1'b0;
                        state_n = WAIT;
                    end
                end
            end

            WAIT: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (wdog_expired) begin
                    state_n = IDLE;
                end else if (h_data_available || tail_ready) begin
                    state_n = READ;
                end
            end

            READ: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    data_n  = h_data;
                    state_n = HOLD;
                end
            end

            HOLD: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (out_ready) begin
                    rem_n  = (remaining != '0) ? (remaining - CNT_W'(1)) : '0;
                    pair_n = mode ? pair : ~pair;
                    if (rem_n == '0) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else if (!mode && pair_n) begin
                        state_n = READ;
                    end else if (GUARD_CYC == 0) begin
                        state_n = WAIT;
                    end else begin
                        grd_n   = GRD_LOAD;
                        state_n = GUARD;
                    end
                end
            end

            GUARD: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (grd_cnt == '0) begin
                    state_n = WAIT;
                end else begin
                    grd_n = grd_cnt - GRD_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign fifo_rd   = (state == READ);
    assign fifo_sel  = (state == READ);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

`ifdef PH_REG3_XFER_TIMEOUT_EN
    logic wdog_en;
    logic wdog_clear;

    assign wdog_en    = (state == WAIT);
    assign wdog_clear = !wdog_en;

    ph_xfer_wdog u_wdog (
        .h_phi2  (h_phi2),
        .h_rst_b (h_rst_b),
        .clear   (wdog_clear),
        .enable  (wdog_en),
        .expired (wdog_expired)
    );

    // Sticky until the next accepted start.
    always_ff @(posedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            err <= 1'b0;
        end else if ((state == IDLE) && start && !abort) begin
            err <= 1'b0;
        end else if ((state == WAIT) && !abort && wdog_expired) begin
            err <= 1'b1;
        end
    end
`else
    assign wdog_expired = 1'b0;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_ph_reg3_xfer_ctrl.sv
// Self-checking bench for ph_reg3_xfer_ctrl: IDLE vector table, directed corner sequences,
// and randomized transfers checked against an event-level model of the transfer rules.
module tb_ph_reg3_xfer_ctrl;

    localparam int CNT_W     = 16;
    localparam int GUARD_CYC = 2;
    localparam int MAXC      = 600;

    logic             h_phi2 = 1'b0;
    logic             h_rst_b;
    logic             start, one_byte_mode, abort;
    logic [CNT_W-1:0] len;
    logic             h_data_available, h_zero_bytes_available, out_ready;
    logic [7:0]       h_data;
    logic             fifo_sel, fifo_rd, out_valid, busy, done, err;
    logic [7:0]       out_data;
    logic [CNT_W-1:0] remaining;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]       fifo_q[$];
    logic [7:0]       src_bytes[$];
    logic [7:0]       acc_bytes[$];
    logic [CNT_W-1:0] rem_trace[$];
    int               strb_cyc[$];
    int               acc_cyc[$];
    int               done_cyc[$];
    int               rem_first;
    int               bad_cycles;
    bit               avail_log[MAXC+1];
    bit               zero_log[MAXC+1];
    bit               ready_log[MAXC+1];

    typedef struct {
        logic             start;
        logic [CNT_W-1:0] len;
        logic             abort;
        logic             exp_busy;
        logic             exp_done;
        logic [CNT_W-1:0] exp_rem;
    } idle_vec_t;

    idle_vec_t vec[8];

    ph_reg3_xfer_ctrl #(.CNT_W(CNT_W), .GUARD_CYC(GUARD_CYC)) dut (
        .h_phi2                 (h_phi2),
        .h_rst_b                (h_rst_b),
        .start                  (start),
        .len                    (len),
        .one_byte_mode          (one_byte_mode),
        .abort                  (abort),
        .h_data_available       (h_data_available),
        .h_zero_bytes_available (h_zero_bytes_available),
        .h_data                 (h_data),
        .fifo_sel               (fifo_sel),
        .fifo_rd                (fifo_rd),
        .out_data               (out_data),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .busy                   (busy),
        .done                   (done),
        .err                    (err),
        .remaining              (remaining)
    );

    always #5 h_phi2 = ~h_phi2;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "global timeout");
    end

    task automatic step();
        @(posedge h_phi2);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        h_data_available = 1'b0; h_zero_bytes_available = 1'b1; h_data = 8'h00;
    endtask

    // Drives one transfer; FIFO bytes come from fifo_q, one per observed strobe.
    task automatic run_xfer(input int xlen, input bit obm, input bit rnd, input bit tail);
        bit acc_prev, fin;
        strb_cyc.delete(); acc_cyc.delete(); done_cyc.delete();
        acc_bytes.delete(); rem_trace.delete();
        bad_cycles = 0; rem_first = -1;
        for (int i = 0; i <= MAXC; i++) begin
            avail_log[i] = 1'b0; zero_log[i] = 1'b1; ready_log[i] = 1'b0;
        end
        start = 1'b1; len = CNT_W'(xlen); one_byte_mode = obm;
        step();
        start = 1'b0;
        acc_prev = 1'b0; fin = 1'b0;
        for (int c = 1; c <= MAXC && !fin; c++) begin
            if (c == 1) rem_first = int'(remaining);
            if (acc_prev) rem_trace.push_back(remaining);
            if (fifo_sel !== fifo_rd) bad_cycles++;
            if (done === 1'b1) begin
                done_cyc.push_back(c);
                fin = 1'b1;
                if (busy !== 1'b0) bad_cycles++;
            end else if (busy !== 1'b1) begin
                bad_cycles++;
            end
            if (fifo_rd === 1'b1) begin
                h_data = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'h00;
                strb_cyc.push_back(c);
            end else begin
                h_data = 8'hEE;
            end
            ready_log[c] = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            avail_log[c] = rnd ? ($urandom_range(0, 2) == 0) : !(tail && (acc_cyc.size() >= xlen - 1));
            zero_log[c]  = rnd ? ($urandom_range(0, 1) == 1) : !tail;
            out_ready = ready_log[c];
            h_data_available = avail_log[c];
            h_zero_bytes_available = zero_log[c];
            acc_prev = (out_valid === 1'b1) && ready_log[c];
            if (acc_prev) begin
                acc_bytes.push_back(out_data);
                acc_cyc.push_back(c);
            end
            if (!fin) step();
        end
        check("xfer_finished", 32'(fin), 32'd1);
        idle_inputs();
    endtask

    // Event-level model: when each strobe and accept must occur, given the logged inputs.
    task automatic check_model(input string tag, input int xlen, input bit obm);
        int w, s, a, ws;
        int exp_s[$];
        int exp_a[$];
        ws = 1; a = 0; s = 0;
        for (int k = 0; k < xlen; k++) begin
            if (!obm && (k % 2 == 1)) begin
                s = a + 1;
            end else begin
                w = ws;
                while (w < MAXC && !(avail_log[w] || (!obm && (xlen - k) == 1 && !zero_log[w]))) w++;
                s = w + 1;
            end
            a = s + 1;
            while (a < MAXC && !ready_log[a]) a++;
            exp_s.push_back(s);
            exp_a.push_back(a);
            ws = a + GUARD_CYC + 1;
        end
        check({tag, "_rem_start"}, rem_first, xlen);
        check({tag, "_strobe_count"}, strb_cyc.size(), xlen);
        check({tag, "_accept_count"}, acc_cyc.size(), xlen);
        for (int k = 0; k < xlen; k++) begin
            check($sformatf("%s_strobe%0d_cyc", tag, k), qget(strb_cyc, k), exp_s[k]);
            check($sformatf("%s_accept%0d_cyc", tag, k), qget(acc_cyc, k), exp_a[k]);
            check($sformatf("%s_byte%0d", tag, k),
                  (k < acc_bytes.size()) ? 32'(acc_bytes[k]) : 32'hFFFF_FFFF, 32'(src_bytes[k]));
            check($sformatf("%s_rem%0d", tag, k),
                  (k < rem_trace.size()) ? 32'(rem_trace[k]) : 32'hFFFF_FFFF, xlen - 1 - k);
        end
        check({tag, "_done_count"}, done_cyc.size(), 1);
        check({tag, "_done_cyc"}, qget(done_cyc, 0), a + 1);
        check({tag, "_busy_sel_consistent"}, bad_cycles, 0);
    endtask

    task automatic load_bytes(input logic [7:0] b);
        fifo_q.push_back(b);
        src_bytes.push_back(b);
    endtask

    initial begin
        bit   got;
        int   nrd;
        int   rl;
        bit   rm;
        vec[0] = '{1'b1, 16'd0,     1'b0, 1'b0, 1'b1, 16'd0};
        vec[1] = '{1'b1, 16'd5,     1'b0, 1'b1, 1'b0, 16'd5};
        vec[2] = '{1'b1, 16'd9,     1'b1, 1'b0, 1'b0, 16'd5};
        vec[3] = '{1'b0, 16'd7,     1'b0, 1'b0, 1'b0, 16'd5};
        vec[4] = '{1'b1, 16'd1,     1'b0, 1'b1, 1'b0, 16'd1};
        vec[5] = '{1'b1, 16'hFFFF,  1'b0, 1'b1, 1'b0, 16'hFFFF};
        vec[6] = '{1'b1, 16'd0,     1'b0, 1'b0, 1'b1, 16'hFFFF};
        vec[7] = '{1'b0, 16'd0,     1'b1, 1'b0, 1'b0, 16'hFFFF};

        idle_inputs();
        len = '0; one_byte_mode = 1'b1;
        h_rst_b = 1'b0;
        #3;
        check("rst_fifo_sel", 32'(fifo_sel), 0);
        check("rst_fifo_rd", 32'(fifo_rd), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_remaining", 32'(remaining), 0);
        step(); step();
        h_rst_b = 1'b1;
        step();

        // IDLE start/abort table
        for (int i = 0; i < 8; i++) begin
            start = vec[i].start; len = vec[i].len; abort = vec[i].abort;
            step();
            start = 1'b0; abort = 1'b0;
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vec[i].exp_busy));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(vec[i].exp_done));
            check($sformatf("vec%0d_remaining", i), 32'(remaining), 32'(vec[i].exp_rem));
            if (vec[i].exp_busy) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                check($sformatf("vec%0d_abort_busy", i), 32'(busy), 0);
                check($sformatf("vec%0d_abort_rem", i), 32'(remaining), 32'(vec[i].exp_rem));
            end
            step();
        end

        // start while busy is ignored
        start = 1'b1; len = 16'd5;
        step();
        len = 16'd3;
        step();
        start = 1'b0;
        check("busy_start_ignored_rem", 32'(remaining), 5);
        check("busy_start_ignored_busy", 32'(busy), 1);
        abort = 1'b1; step(); abort = 1'b0; step();

        // one-byte mode, len 3
        src_bytes.delete(); fifo_q.delete();
        load_bytes(8'h11); load_bytes(8'h22); load_bytes(8'h33);
        run_xfer(3, 1'b1, 1'b0, 1'b0);
        check_model("obm3", 3, 1'b1);
        check("obm3_strobe0", qget(strb_cyc, 0), 2);
        check("obm3_strobe1", qget(strb_cyc, 1), 7);
        check("obm3_strobe2", qget(strb_cyc, 2), 12);
        check("obm3_done", qget(done_cyc, 0), 14);

        // two-byte mode, len 4
        src_bytes.delete(); fifo_q.delete();
        load_bytes(8'hA1); load_bytes(8'hB2); load_bytes(8'hC3); load_bytes(8'hD4);
        run_xfer(4, 1'b0, 1'b0, 1'b0);
        check_model("tbm4", 4, 1'b0);
        check("tbm4_strobe1", qget(strb_cyc, 1), 4);
        check("tbm4_strobe2", qget(strb_cyc, 2), 9);
        check("tbm4_strobe3", qget(strb_cyc, 3), 11);
        check("tbm4_done", qget(done_cyc, 0), 13);

        // two-byte mode, len 3, odd tail signalled only by zero_bytes_available=0
        src_bytes.delete(); fifo_q.delete();
        load_bytes(8'h5C); load_bytes(8'h6D); load_bytes(8'h7E);
        run_xfer(3, 1'b0, 1'b0, 1'b1);
        check_model("tail3", 3, 1'b0);
        check("tail3_strobe2", qget(strb_cyc, 2), 9);
        check("tail3_done", qget(done_cyc, 0), 11);

        // out_ready stalled in HOLD
        start = 1'b1; len = 16'd1; one_byte_mode = 1'b1; h_data_available = 1'b1;
        step();
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (fifo_rd === 1'b1) begin
                got = 1'b1;
                h_data = 8'h5A;
            end else begin
                step();
            end
        end
        check("stall_strobe_seen", 32'(got), 1);
        h_data_available = 1'b0;
        step();
        h_data = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_valid", i), 32'(out_valid), 1);
            check($sformatf("stall%0d_data", i), 32'(out_data), 32'h5A);
            check($sformatf("stall%0d_no_strobe", i), 32'(fifo_rd), 0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("stall_done", 32'(done), 1);
        check("stall_valid_after", 32'(out_valid), 0);
        step();

        // abort during GUARD with remaining 7
        start = 1'b1; len = 16'd8; one_byte_mode = 1'b1;
        h_data_available = 1'b1; out_ready = 1'b1;
        step();
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (remaining === 16'd7) got = 1'b1;
            else step();
        end
        check("guard_abort_reached", 32'(got), 1);
        check("guard_abort_pre_busy", 32'(busy), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("guard_abort_busy", 32'(busy), 0);
        check("guard_abort_rem", 32'(remaining), 7);
        check("guard_abort_done", 32'(done), 0);
        check("guard_abort_valid", 32'(out_valid), 0);
        step();
        check("guard_abort_done_later", 32'(done), 0);
        idle_inputs();

        // abort in the READ cycle discards the byte
        start = 1'b1; len = 16'd2; h_data_available = 1'b1;
        step();
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (fifo_rd === 1'b1) got = 1'b1;
            else step();
        end
        check("read_abort_strobe_seen", 32'(got), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("read_abort_valid", 32'(out_valid), 0);
        check("read_abort_busy", 32'(busy), 0);
        check("read_abort_rem", 32'(remaining), 2);
        check("read_abort_done", 32'(done), 0);
        idle_inputs();
        step();

        // randomized transfers
        for (int t = 0; t < 20; t++) begin
            rl = $urandom_range(1, 6);
            rm = 1'($urandom_range(0, 1));
            src_bytes.delete(); fifo_q.delete();
            for (int k = 0; k < rl; k++) load_bytes(8'($urandom_range(0, 255)));
            run_xfer(rl, rm, 1'b1, 1'b0);
            check_model($sformatf("rnd%0d", t), rl, rm);
        end

        // reset mid-transfer
        start = 1'b1; len = 16'd3; one_byte_mode = 1'b1;
        h_data_available = 1'b1; out_ready = 1'b0; h_data = 8'h9C;
        step();
        start = 1'b0;
        step(); step();
        check("midrst_pre_valid", 32'(out_valid), 1);
        h_rst_b = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_data", 32'(out_data), 0);
        check("midrst_rem", 32'(remaining), 0);
        step();
        h_rst_b = 1'b1;
        idle_inputs();
        step();
        check("midrst_no_done", 32'(done), 0);
        check("midrst_idle", 32'(busy), 0);

        // WAIT with no data ever arriving
        start = 1'b1; len = 16'd2; one_byte_mode = 1'b1;
        step();
        start = 1'b0;
`ifdef PH_REG3_XFER_TIMEOUT_EN
        repeat (254) step();
        check("wdog_pre_err", 32'(err), 0);
        check("wdog_pre_busy", 32'(busy), 1);
        step();
        check("wdog_err", 32'(err), 1);
        check("wdog_busy", 32'(busy), 0);
        check("wdog_no_done", 32'(done), 0);
        step();
        check("wdog_err_sticky", 32'(err), 1);
        start = 1'b1; len = 16'd0;
        step();
        start = 1'b0;
        check("wdog_err_cleared", 32'(err), 0);
        check("wdog_len0_done", 32'(done), 1);
`else
        nrd = 0;
        for (int i = 0; i < 1000; i++) begin
            if (fifo_rd === 1'b1) nrd++;
            step();
        end
        check("wait_forever_busy", 32'(busy), 1);
        check("wait_forever_no_strobe", nrd, 0);
        check("wait_forever_err", 32'(err), 0);
        check("wait_forever_rem", 32'(remaining), 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("wait_forever_abort", 32'(busy), 0);
`endif
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
